// File: rtl/puf_arbiter.sv
// Round-robin arbiter for two clients sharing a DD and an XOR PUF.
// Define PUF_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles with ERR set.
//
// state   | meaning
// IDLE    | no owner, arbitrate on any request
// GRANT   | owner granted, select and count latched
// LAUNCH  | one-cycle start pulse to the selected PUF
// WAIT    | waiting for the selected PUF's done
// CAPTURE | result valid, ack pulse to owner
// RELEASE | hold grant until the owner drops its request
module puf_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         REQ_A,
    input  logic         REQ_B,
    input  logic         SEL_A,
    input  logic         SEL_B,
    input  logic [15:0]  CNT_A,
    input  logic [15:0]  CNT_B,
    output logic         GNT_A,
    output logic         GNT_B,
    output logic         ACK_A,
    output logic         ACK_B,
    output logic [127:0] RESULT,
    output logic         ERR,
    output logic         START_DD,
    output logic         START_XOR,
    output logic [15:0]  CNT_VAL,
    input  logic         DONE_DD,
    input  logic         DONE_XOR,
    input  logic [127:0] PUF_OUT_DD,
    input  logic [127:0] PUF_OUT_XOR
);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_LAUNCH, S_WAIT, S_CAPTURE, S_RELEASE
    } state_t;

    state_t        state, next_state;
    logic          owner_b;
    logic          last_b;
    logic          sel_lat;
    logic [15:0]   cnt_lat;
    logic [127:0]  result_q;

    logic          any_req;
    logic          win_b;
    logic          win_sel;
    logic [15:0]   win_cnt;
    logic          req_owner;
    logic          done_sel;
    logic          timeout_hit;

    assign any_req   = REQ_A | REQ_B;
    // Sole requester wins; on a tie the side not granted last wins.
    assign win_b     = REQ_B & (~REQ_A | ~last_b);
    assign win_sel   = win_b ? SEL_B : SEL_A;
    assign win_cnt   = win_b ? CNT_B : CNT_A;
    assign req_owner = owner_b ? REQ_B : REQ_A;
    assign done_sel  = sel_lat ? DONE_XOR : DONE_DD;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (any_req) next_state = S_GRANT;
            S_GRANT:   next_state = S_LAUNCH;
            S_LAUNCH:  next_state = S_WAIT;
            S_WAIT:    if (done_sel || timeout_hit) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_RELEASE;
            S_RELEASE: if (!req_owner) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        GNT_A     = 1'b0;
        GNT_B     = 1'b0;
        ACK_A     = 1'b0;
        ACK_B     = 1'b0;
        START_DD  = 1'b0;
        START_XOR = 1'b0;
        CNT_VAL   = 16'd1;
        if (state != S_IDLE) begin
            GNT_A   = ~owner_b;
            GNT_B   = owner_b;
            CNT_VAL = cnt_lat;
        end
        if (state == S_LAUNCH) begin
            START_DD  = ~sel_lat;
            START_XOR = sel_lat;
        end
        if (state == S_CAPTURE) begin
            ACK_A = ~owner_b;
            ACK_B = owner_b;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            owner_b  <= 1'b0;
            last_b   <= 1'b1;
            sel_lat  <= 1'b0;
            cnt_lat  <= 16'd1;
            result_q <= '0;
        end else begin
            if (state == S_IDLE && any_req) begin
                owner_b <= win_b;
                sel_lat <= win_sel;
                cnt_lat <= (win_cnt == 16'd0) ? 16'd1 : win_cnt;
            end
            if (state == S_WAIT) begin
                if (done_sel)
                    result_q <= sel_lat ? PUF_OUT_XOR : PUF_OUT_DD;
                else if (timeout_hit)
                    result_q <= '0;
            end
            if (state == S_RELEASE && !req_owner)
                last_b <= owner_b;
        end
    end

    assign RESULT = result_q;

`ifdef PUF_TIMEOUT_EN
    logic [15:0] tmr;
    logic        err_q;

    assign timeout_hit = (tmr == 16'd0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmr   <= 16'd0;
            err_q <= 1'b0;
        end else begin
            if (state == S_LAUNCH)
                tmr <= TIMEOUT - 16'd1;
            else if (state == S_WAIT && tmr != 16'd0)
                tmr <= tmr - 16'd1;
            // done wins over a timeout landing in the same cycle
            if (state == S_WAIT) begin
                if (done_sel)         err_q <= 1'b0;
                else if (timeout_hit) err_q <= 1'b1;
            end
        end
    end

    assign ERR = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign ERR            = 1'b0;
`endif

endmodule
